// File: rtl/wb_arb_pkg.sv
// Shared defaults and types for the register-file write-port arbiter.
package wb_arb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_AW     = 5;
  localparam int STARVE_MAX = 4;

  typedef enum logic [1:0] {SRC_NONE, SRC_PIPE, SRC_LLU} wb_src_e;

  typedef logic [REG_AW-1:0] reg_addr_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-destination busy vector: set on LLU issue, clear on LLU writeback, set wins.
// Two combinational read ports of registered state; no backpressure.
module wb_scoreboard #(
  parameter int REG_AW = wb_arb_pkg::REG_AW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   set_vld,
  input  logic [REG_AW-1:0]      set_idx,
  input  logic                   clr_vld,
  input  logic [REG_AW-1:0]      clr_idx,
  input  logic [REG_AW-1:0]      rd0_idx,
  output logic                   rd0_busy,
  input  logic [REG_AW-1:0]      rd1_idx,
  output logic                   rd1_busy,
  output logic [2**REG_AW-1:0]   busy_vec
);

  logic [2**REG_AW-1:0] busy_d, busy_q;

  always_comb begin
    busy_d = busy_q;
    if (clr_vld) busy_d[clr_idx] = 1'b0;
    if (set_vld) busy_d[set_idx] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign rd0_busy = busy_q[rd0_idx];
  assign rd1_busy = busy_q[rd1_idx];
  assign busy_vec = busy_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between WB and the LLU; output registered (latency 1).
// Pipeline has priority; after STARVE_MAX denied LLU cycles the pipeline is stalled for one LLU slot.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int XLEN       = wb_arb_pkg::XLEN,
  parameter int REG_AW     = wb_arb_pkg::REG_AW,
  parameter int STARVE_MAX = wb_arb_pkg::STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_we,
  input  logic [REG_AW-1:0] pipe_waddr,
  input  logic [XLEN-1:0]   pipe_wdata,
  output logic              pipe_stall,
  input  logic              llu_valid,
  output logic              llu_ready,
  input  logic [REG_AW-1:0] llu_waddr,
  input  logic [XLEN-1:0]   llu_wdata,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic              rs1_pending,
  output logic              rs2_pending,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  wb_src_e             src;
  logic                force_llu;
  logic [3:0]          starve_cnt_d, starve_cnt_q;
  logic                rf_we_d, rf_we_q;
  logic [REG_AW-1:0]   rf_waddr_d, rf_waddr_q;
  logic [XLEN-1:0]     rf_wdata_d, rf_wdata_q;
  logic                rd0_busy, rd1_busy;
  logic [2**REG_AW-1:0] busy_vec;

  always_comb begin
    force_llu    = (starve_cnt_q == STARVE_LIM);
    src          = SRC_NONE;
    starve_cnt_d = starve_cnt_q;
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;

    if (pipe_we && !(force_llu && llu_valid)) src = SRC_PIPE;
    else if (llu_valid)                       src = SRC_LLU;

    // Counter is only ever below the limit when it increments, so it saturates naturally.
    if (!llu_valid || src == SRC_LLU)  starve_cnt_d = '0;
    else if (pipe_we && !force_llu)    starve_cnt_d = starve_cnt_q + 4'd1;

    case (src)
      SRC_PIPE: begin
        rf_we_d    = (pipe_waddr != '0);
        rf_waddr_d = pipe_waddr;
        rf_wdata_d = pipe_wdata;
      end
      SRC_LLU: begin
        rf_we_d    = (llu_waddr != '0);
        rf_waddr_d = llu_waddr;
        rf_wdata_d = llu_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

  wb_scoreboard #(.REG_AW(REG_AW)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_vld  (issue_valid && (issue_rd != '0)),
    .set_idx  (issue_rd),
    .clr_vld  (src == SRC_LLU),
    .clr_idx  (llu_waddr),
    .rd0_idx  (rs1_addr),
    .rd0_busy (rd0_busy),
    .rd1_idx  (rs2_addr),
    .rd1_busy (rd1_busy),
    .busy_vec (busy_vec)
  );

  assign llu_ready   = (src == SRC_LLU) && !rst;
  assign pipe_stall  = pipe_we && force_llu && llu_valid && !rst;
  assign rs1_pending = rd0_busy && !rst;
  assign rs2_pending = rd1_busy && !rst;
  assign rf_we       = rf_we_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;

  // Re-issuing a destination is legal only when its previous result retires in the same cycle.
  a_issue_busy: assert property (@(posedge clk) disable iff (rst)
    (issue_valid && issue_rd != '0) |->
      (!busy_vec[issue_rd] || (src == SRC_LLU && llu_waddr == issue_rd)))
    else $error("issue to busy rd %0d", issue_rd);

  a_pipe_busy: assert property (@(posedge clk) disable iff (rst)
    pipe_we |-> !busy_vec[pipe_waddr])
    else $error("pipeline write to busy rd %0d", pipe_waddr);

  a_llu_idle: assert property (@(posedge clk) disable iff (rst)
    (llu_valid && llu_waddr != '0) |-> busy_vec[llu_waddr])
    else $error("LLU write to non-busy rd %0d", llu_waddr);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with hand-computed expectations.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        pipe_stall;
  logic        llu_valid;
  logic        llu_ready;
  logic [4:0]  llu_waddr;
  logic [31:0] llu_wdata;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_pending, rs2_pending;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wb_port_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .pipe_we     (pipe_we),
    .pipe_waddr  (pipe_waddr),
    .pipe_wdata  (pipe_wdata),
    .pipe_stall  (pipe_stall),
    .llu_valid   (llu_valid),
    .llu_ready   (llu_ready),
    .llu_waddr   (llu_waddr),
    .llu_wdata   (llu_wdata),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_pending (rs1_pending),
    .rs2_pending (rs2_pending),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    pipe_we = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
    llu_valid = 1'b0; llu_waddr = '0; llu_wdata = '0;
    issue_valid = 1'b0; issue_rd = '0;
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    rs1_addr = '0; rs2_addr = '0;
    idle();
    tick(); tick();

    // Reset state
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk("rst_llu_ready", 32'(llu_ready), 32'd0);
    chk("rst_pipe_stall", 32'(pipe_stall), 32'd0);
    chk("rst_cnt", 32'(dut.starve_cnt_q), 32'd0);
    rst = 1'b0;
    tick();

    // Pipeline only
    pipe_we = 1'b1; pipe_waddr = 5'd5; pipe_wdata = 32'h12345678;
    #1;
    chk("pipe_llu_ready", 32'(llu_ready), 32'd0);
    chk("pipe_stall0", 32'(pipe_stall), 32'd0);
    tick();
    idle();
    chk("pipe_rf_we", 32'(rf_we), 32'd1);
    chk("pipe_rf_waddr", 32'(rf_waddr), 32'd5);
    chk("pipe_rf_wdata", rf_wdata, 32'h12345678);
    tick();
    chk("idle_rf_we", 32'(rf_we), 32'd0);

    // LLU only
    rs1_addr = 5'd7;
    issue_valid = 1'b1; issue_rd = 5'd7;
    #1;
    chk("llu_pend_same_cycle", 32'(rs1_pending), 32'd0);
    tick();
    idle();
    chk("llu_pend_set", 32'(rs1_pending), 32'd1);
    llu_valid = 1'b1; llu_waddr = 5'd7; llu_wdata = 32'hDEADBEEF;
    #1;
    chk("llu_ready", 32'(llu_ready), 32'd1);
    chk("llu_pend_at_grant", 32'(rs1_pending), 32'd1);
    tick();
    idle();
    chk("llu_rf_we", 32'(rf_we), 32'd1);
    chk("llu_rf_waddr", 32'(rf_waddr), 32'd7);
    chk("llu_rf_wdata", rf_wdata, 32'hDEADBEEF);
    chk("llu_pend_clr", 32'(rs1_pending), 32'd0);

    // Starvation: four denied cycles, then a forced LLU slot
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    idle();
    rs2_addr = 5'd3;
    pipe_we = 1'b1; pipe_waddr = 5'd10; pipe_wdata = 32'hAAAA0010;
    llu_valid = 1'b1; llu_waddr = 5'd3; llu_wdata = 32'h33333333;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("starve_stall_%0d", i), 32'(pipe_stall), 32'd0);
      chk($sformatf("starve_ready_%0d", i), 32'(llu_ready), 32'd0);
      tick();
      chk($sformatf("starve_rf_waddr_%0d", i), 32'(rf_waddr), 32'd10);
    end
    #1;
    chk("force_stall", 32'(pipe_stall), 32'd1);
    chk("force_ready", 32'(llu_ready), 32'd1);
    chk("force_pend_before", 32'(rs2_pending), 32'd1);
    tick();
    llu_valid = 1'b0;
    chk("force_rf_waddr", 32'(rf_waddr), 32'd3);
    chk("force_rf_wdata", rf_wdata, 32'h33333333);
    chk("force_pend_after", 32'(rs2_pending), 32'd0);
    #1;
    chk("held_stall", 32'(pipe_stall), 32'd0);
    tick();
    idle();
    chk("held_rf_waddr", 32'(rf_waddr), 32'd10);
    chk("held_rf_wdata", rf_wdata, 32'hAAAA0010);
    chk("held_cnt", 32'(dut.starve_cnt_q), 32'd0);

    // x0 writes and issues
    pipe_we = 1'b1; pipe_waddr = 5'd0; pipe_wdata = 32'hFFFFFFFF;
    tick();
    idle();
    chk("x0_rf_we", 32'(rf_we), 32'd0);
    issue_valid = 1'b1; issue_rd = 5'd0;
    tick();
    idle();
    rs1_addr = 5'd0;
    #1;
    chk("x0_pending", 32'(rs1_pending), 32'd0);

    // Simultaneous set and clear of rd=9
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    idle();
    llu_valid = 1'b1; llu_waddr = 5'd9; llu_wdata = 32'h99999999;
    issue_valid = 1'b1; issue_rd = 5'd9;
    #1;
    chk("sim_ready", 32'(llu_ready), 32'd1);
    tick();
    idle();
    rs1_addr = 5'd9;
    #1;
    chk("sim_pending", 32'(rs1_pending), 32'd1);
    chk("sim_rf_waddr", 32'(rf_waddr), 32'd9);

    // Reset mid-operation
    issue_valid = 1'b1; issue_rd = 5'd4;
    tick();
    issue_rd = 5'd6;
    tick();
    idle();
    rs1_addr = 5'd4; rs2_addr = 5'd6;
    pipe_we = 1'b1; pipe_waddr = 5'd11; pipe_wdata = 32'h0000000B;
    llu_valid = 1'b1; llu_waddr = 5'd4; llu_wdata = 32'h44444444;
    tick(); tick();
    chk("mid_cnt2", 32'(dut.starve_cnt_q), 32'd2);
    chk("mid_pend4", 32'(rs1_pending), 32'd1);
    chk("mid_pend6", 32'(rs2_pending), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(llu_ready), 32'd0);
    chk("mid_rst_stall", 32'(pipe_stall), 32'd0);
    chk("mid_rst_pend", 32'(rs1_pending), 32'd0);
    tick();
    rst = 1'b0;
    idle();
    #1;
    chk("post_rst_rf_we", 32'(rf_we), 32'd0);
    chk("post_rst_pend4", 32'(rs1_pending), 32'd0);
    chk("post_rst_pend6", 32'(rs2_pending), 32'd0);
    chk("post_rst_cnt", 32'(dut.starve_cnt_q), 32'd0);
    rs1_addr = 5'd9;
    #1;
    chk("post_rst_pend9", 32'(rs1_pending), 32'd0);

    // Back-to-back LLU grants with no pipeline traffic
    issue_valid = 1'b1; issue_rd = 5'd12;
    tick();
    issue_rd = 5'd13;
    tick();
    idle();
    llu_valid = 1'b1; llu_waddr = 5'd12; llu_wdata = 32'h0000000C;
    #1;
    chk("b2b_ready0", 32'(llu_ready), 32'd1);
    tick();
    llu_waddr = 5'd13; llu_wdata = 32'h0000000D;
    #1;
    chk("b2b_ready1", 32'(llu_ready), 32'd1);
    chk("b2b_rf_waddr0", 32'(rf_waddr), 32'd12);
    tick();
    idle();
    chk("b2b_rf_waddr1", 32'(rf_waddr), 32'd13);
    chk("b2b_rf_wdata1", rf_wdata, 32'h0000000D);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the in-order pipeline writeback stage and a long-latency unit (LLU, e.g. divider or load miss return). It keeps a 32-entry pending-destination scoreboard so decode can detect hazards on LLU results still in flight. A starvation counter forces an LLU slot by stalling the pipeline. The block sits between the WB stage, the LLU and the register file, and drives the register-file write port through one register stage.

## Interface
Parameters:
- XLEN, 32, data width
- REG_AW, 5, register address width (2**REG_AW registers; x0 hardwired zero)
- STARVE_MAX, 4, consecutive denied LLU cycles before a forced grant (1..15)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- pipe_we  in  1  pipeline WB write request
- pipe_waddr  in  REG_AW  pipeline destination
- pipe_wdata  in  XLEN  pipeline data
- pipe_stall  out  1  hold WB stage this cycle (combinational)
- llu_valid  in  1  LLU result valid
- llu_ready  out  1  LLU result accepted (combinational)
- llu_waddr  in  REG_AW  LLU destination
- llu_wdata  in  XLEN  LLU data
- issue_valid  in  1  an LLU op issued this cycle
- issue_rd  in  REG_AW  destination of the issued op
- rs1_addr, rs2_addr  in  REG_AW  decode source operands
- rs1_pending, rs2_pending  out  1  source has an LLU write outstanding (combinational)
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  REG_AW  registered write address
- rf_wdata  out  XLEN  registered write data

## Operation
- force = (starve_cnt == STARVE_MAX).
- Grant source per cycle:
  - PIPE if pipe_we && !(force && llu_valid).
  - Else LLU if llu_valid.
  - Else NONE.
- llu_ready = llu_valid && (!pipe_we || force) && !rst.
- pipe_stall = pipe_we && force && llu_valid. A stalled pipeline re-presents the same write next cycle.
- starve_cnt:
  - Reset to 0 on LLU grant or when !llu_valid.
  - Increments when llu_valid && pipe_we && !force.
  - Saturates at STARVE_MAX.
- Equivalent FSM:
  - IDLE (cnt=0, no LLU waiting).
  - WAIT (0<cnt<STARVE_MAX).
  - FORCE (cnt=STARVE_MAX). FORCE always grants LLU that cycle and returns to IDLE.
- Writes to x0 are consumed (the handshake completes) but produce rf_we=0.
- Scoreboard busy[2**REG_AW]:
  - Set busy[issue_rd] on issue_valid (issue_rd != 0).
  - Clear busy[llu_waddr] on LLU grant.
  - Set and clear on the same index in the same cycle: set wins.
  - busy[0] is constant 0.
- rsN_pending = busy[rsN_addr]. Combinational read of registered state; no bypass of same-cycle issue or clear.
- Illegal, flagged by assertion:
  - issue_valid to an already-busy rd.
  - pipe_we to a busy register.
  - llu_valid to a non-busy register.

## Timing
- Grant decision is combinational in cycle N. rf_we/rf_waddr/rf_wdata reflect it in cycle N+1 (latency 1).
- A cleared busy bit is visible on rsN_pending in cycle N+1, the same cycle the register-file write occurs. Decode relies on register-file write-before-read.
- Reset values:
  - rf_we=0, rf_waddr=0, rf_wdata=0, starve_cnt=0, all busy=0.
  - During rst: llu_ready=0, pipe_stall=0, rsN_pending=0.
- Reset mid-operation drops all pending entries. The LLU must be reset in the same cycle.
- Back-to-back LLU grants are allowed every cycle when pipe_we=0.

## Structure
- Package wb_arb_pkg holds:
  - XLEN, REG_AW, STARVE_MAX defaults.
  - typedef enum logic [1:0] {SRC_NONE, SRC_PIPE, SRC_LLU} wb_src_e.
  - typedef logic [REG_AW-1:0] reg_addr_t.
- One sub-module, wb_scoreboard: busy vector with set/clear ports and two read ports. The arbiter, starvation counter and output register stay in wb_port_arbiter.

## Test plan
- Pipeline only: pipe_we=1, waddr=5, wdata=32'h12345678 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=32'h12345678; llu_ready=0.
- LLU only: issue rd=7; LLU valid for rd=7, data 32'hDEADBEEF -> llu_ready=1 same cycle; rf write to 7 next cycle; rs1_addr=7 pending=1 before the grant and 0 from the grant+1 cycle.
- Starvation: pipe_we=1 every cycle, llu_valid=1 (rd=3) -> 4 denied cycles, 5th cycle pipe_stall=1, llu_ready=1, rf_waddr=3 next cycle; the held pipe write commits the following cycle.
- x0: pipe_we to x0 -> rf_we=0; issue rd=0 -> rs1_pending for x0 stays 0.
- Simultaneous: issue rd=9 and LLU grant clearing rd=9 in the same cycle -> busy[9]=1 afterwards.
- Reset mid-operation: busy bits for rd=4 and rd=6 set, starve_cnt=2, assert rst one cycle -> all pending=0, rf_we=0, counter 0, llu_ready=0 during rst.
